// File: rtl/phy_pkg.sv
// Shared constants and types for the receive-side lane demultiplexer.
package phy_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int NUM_LANES = 4;
    localparam int SLOT_W    = 2;

    // Last slot of a frame; the frame is presented when this slot's byte arrives.
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_LANES - 1);

    typedef enum logic {
        SEEK   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

endpackage

// File: rtl/phy_rx_demux_if.sv
// Byte-stream input and four-lane output bundle of the receive demultiplexer.
interface phy_rx_demux_if
    import phy_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic [WIDTH-1:0] data_0;
    logic [WIDTH-1:0] data_1;
    logic [WIDTH-1:0] data_2;
    logic [WIDTH-1:0] data_3;
    logic             valid_0;
    logic             valid_1;
    logic             valid_2;
    logic             valid_3;
    logic             frame_strobe;
    logic             locked;

    // Upstream side: drives the byte stream, observes the lanes.
    modport master (
        output data_in, valid_in,
        input  data_0, data_1, data_2, data_3,
        input  valid_0, valid_1, valid_2, valid_3,
        input  frame_strobe, locked
    );

    // Demultiplexer side.
    modport slave (
        input  data_in, valid_in,
        output data_0, data_1, data_2, data_3,
        output valid_0, valid_1, valid_2, valid_3,
        output frame_strobe, locked
    );

endinterface

// File: rtl/phy_rx_lock_fsm.sv
// Frame alignment: SEEK/LOCKED state, slot counter within the frame and
// idle-run counter that forces a return to SEEK after too many gaps.
module phy_rx_lock_fsm
    import phy_pkg::*;
#(
    parameter int IDLE_LIMIT = 8
) (
    input  logic              clk_4f,
    input  logic              reset_L,
    input  logic              valid_in,
    output logic [SLOT_W-1:0] slot,
    output logic              locked,
    output logic              drop
);

    localparam int                IDLE_W   = 8;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_LIMIT);

    lock_state_t       state, state_nxt;
    logic [SLOT_W-1:0] slot_nxt;
    logic [IDLE_W-1:0] idle_cnt, idle_nxt;

    // State, slot and idle registers.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state    <= SEEK;
            slot     <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            slot     <= slot_nxt;
            idle_cnt <= idle_nxt;
        end
    end

    // Next-state logic: lock on first valid byte, drop on a long idle run.
    // NOTE: every output of this block is given a default first so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        idle_nxt  = idle_cnt;
        drop      = 1'b0;
        case (state)
            SEEK: begin
                slot_nxt = '0;
                idle_nxt = '0;
                if (valid_in) begin
                    // This byte is slot 0; the next one is slot 1.
                    state_nxt = LOCKED;
                    slot_nxt  = SLOT_W'(1);
                end
            end
            LOCKED: begin
                slot_nxt = slot + SLOT_W'(1);
                if (valid_in) begin
                    idle_nxt = '0;
                end else if (idle_cnt != IDLE_MAX) begin
                    idle_nxt = idle_cnt + IDLE_W'(1);
                end
                // Lock is lost on the edge where the run reaches the limit.
                if (!valid_in && idle_nxt == IDLE_MAX) begin
                    drop      = 1'b1;
                    state_nxt = SEEK;
                    slot_nxt  = '0;
                    idle_nxt  = '0;
                end
            end
        endcase
    end

    assign locked = (state == LOCKED);

endmodule

// File: rtl/phy_rx_demux.sv
// Distributes a byte stream round-robin onto four lanes, presenting all four
// lanes together once per 4-byte frame with a one-cycle strobe.
module phy_rx_demux
    import phy_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int IDLE_LIMIT = 8
) (
    input  logic         clk_4f,
    input  logic         reset_L,
    phy_rx_demux_if.slave bus
);

    localparam int NCAP = NUM_LANES - 1;

    logic [SLOT_W-1:0]    slot;
    logic                 locked;
    logic                 drop;
    logic                 frame;
    logic [WIDTH-1:0]     cap [NCAP];
    logic [NCAP-1:0]      cv;
    logic [WIDTH-1:0]     lane [NUM_LANES];
    logic [NUM_LANES-1:0] lane_valid;
    logic                 strobe;

    phy_rx_lock_fsm #(
        .IDLE_LIMIT (IDLE_LIMIT)
    ) u_lock_fsm (
        .clk_4f   (clk_4f),
        .reset_L  (reset_L),
        .valid_in (bus.valid_in),
        .slot     (slot),
        .locked   (locked),
        .drop     (drop)
    );

    // The last byte of a frame bypasses the capture stage straight to lane 3.
    assign frame = locked && (slot == LAST_SLOT);

    // Capture slots 0..2 of the frame in progress; a lost lock clears them.
    // NOTE: the capture bank is reset explicitly so a frame interrupted by
    // reset can never leak stale bytes into the next one.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            for (int k = 0; k < NCAP; k++) cap[k] <= '0;
            cv <= '0;
        end else if (drop) begin
            for (int k = 0; k < NCAP; k++) cap[k] <= '0;
            cv <= '0;
        end else if (locked || bus.valid_in) begin
            for (int k = 0; k < NCAP; k++) begin
                if (slot == SLOT_W'(k)) begin
                    cap[k] <= bus.data_in;
                    cv[k]  <= bus.valid_in;
                end
            end
        end
    end

    // Lane output registers: load on the frame's last byte, hold otherwise.
    // A drop coinciding with the last slot still presents the frame, but the
    // SEEK entry forces every lane valid low on that same edge.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            for (int k = 0; k < NUM_LANES; k++) lane[k] <= '0;
            lane_valid <= '0;
            strobe     <= 1'b0;
        end else begin
            strobe <= frame;
            if (frame) begin
                for (int k = 0; k < NCAP; k++) lane[k] <= cap[k];
                lane[NUM_LANES-1] <= bus.data_in;
                lane_valid        <= {bus.valid_in, cv};
            end
            if (drop) begin
                lane_valid <= '0;
            end
        end
    end

    assign bus.data_0       = lane[0];
    assign bus.data_1       = lane[1];
    assign bus.data_2       = lane[2];
    assign bus.data_3       = lane[3];
    assign bus.valid_0      = lane_valid[0];
    assign bus.valid_1      = lane_valid[1];
    assign bus.valid_2      = lane_valid[2];
    assign bus.valid_3      = lane_valid[3];
    assign bus.frame_strobe = strobe;
    assign bus.locked       = locked;

endmodule

// File: tb/tb_phy_rx_demux.sv
// Self-checking bench for phy_rx_demux: directed scenarios followed by a
// randomized stream, all compared against a queue-based frame model.
`timescale 1ns/1ps
module tb_phy_rx_demux;

    localparam int WIDTH      = 8;
    localparam int IDLE_LIMIT = 8;

    logic clk_4f;
    logic reset_L;

    phy_rx_demux_if #(.WIDTH(WIDTH)) bus ();

    phy_rx_demux #(
        .WIDTH      (WIDTH),
        .IDLE_LIMIT (IDLE_LIMIT)
    ) dut (
        .clk_4f  (clk_4f),
        .reset_L (reset_L),
        .bus     (bus)
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: bytes of the frame in progress are queued; a full
    // queue of four is a frame.
    typedef struct packed {
        logic [7:0] d;
        logic       v;
    } item_t;

    item_t      m_buf[$];
    bit         m_locked;
    int         m_idle;
    logic [31:0] e_data;
    logic [3:0]  e_valid;
    logic        e_strobe;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_buf.delete();
        m_locked = 0;
        m_idle   = 0;
        e_data   = '0;
        e_valid  = '0;
        e_strobe = 1'b0;
    endfunction

    // Advance the model by one input byte; expected outputs reflect the
    // state right after the clock edge that consumes it.
    function automatic void model_step(input logic [7:0] d, input logic v);
        bit lost;
        lost     = 0;
        e_strobe = 1'b0;
        if (!m_locked) begin
            if (v) begin
                m_buf.delete();
                m_buf.push_back({d, 1'b1});
                m_locked = 1;
                m_idle   = 0;
            end
        end else begin
            m_buf.push_back({d, v});
            if (v) m_idle = 0;
            else if (m_idle < IDLE_LIMIT) m_idle = m_idle + 1;
            lost = (m_idle == IDLE_LIMIT);
            if (m_buf.size() == 4) begin
                for (int k = 0; k < 4; k++) begin
                    e_data[8*k +: 8] = m_buf[k].d;
                    e_valid[k]       = m_buf[k].v;
                end
                e_strobe = 1'b1;
                m_buf.delete();
            end
            if (lost) begin
                m_locked = 0;
                m_idle   = 0;
                m_buf.delete();
                e_valid  = '0;
            end
        end
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".strobe"}, 32'(bus.frame_strobe), 32'(e_strobe));
        check({tag, ".locked"}, 32'(bus.locked), 32'(m_locked));
        check({tag, ".valid"},
              32'({bus.valid_3, bus.valid_2, bus.valid_1, bus.valid_0}), 32'(e_valid));
        check({tag, ".data"},
              {bus.data_3, bus.data_2, bus.data_1, bus.data_0}, e_data);
    endtask

    // Present one byte at the falling edge, let the rising edge consume it,
    // then compare at the next falling edge.
    task automatic cycle(input string tag, input logic [7:0] d, input logic v);
        bus.data_in  = d;
        bus.valid_in = v;
        model_step(d, v);
        @(negedge clk_4f);
        compare_all(tag);
    endtask

    initial begin
        int p;
        reset_L      = 1'b0;
        bus.data_in  = '0;
        bus.valid_in = 1'b0;
        model_reset();
        #12;
        compare_all("reset_held");
        @(negedge clk_4f);
        reset_L = 1'b1;
        compare_all("reset_release");

        // Idle cycles in SEEK: nothing locks, nothing strobes.
        for (int i = 0; i < 3; i++) cycle("seek_idle", 8'(8'hE0 + i), 1'b0);

        // First frame A0..A3.
        for (int i = 0; i < 4; i++) cycle("frame_a", 8'(8'hA0 + i), 1'b1);

        // Continuous stream 00..0F: four frames spaced four cycles apart.
        for (int i = 0; i < 16; i++) cycle("stream", 8'(i), 1'b1);

        // Slot 2 invalid only.
        cycle("gap_slot2", 8'h10, 1'b1);
        cycle("gap_slot2", 8'h11, 1'b1);
        cycle("gap_slot2", 8'h12, 1'b0);
        cycle("gap_slot2", 8'h13, 1'b1);

        // Loss of lock: one valid byte then eight invalid ones, then 0x55
        // starts a fresh frame.
        cycle("lose_lock", 8'h20, 1'b1);
        for (int i = 0; i < IDLE_LIMIT; i++) cycle("lose_lock", 8'(8'h30 + i), 1'b0);
        cycle("relock", 8'h55, 1'b1);
        cycle("relock", 8'h56, 1'b1);
        cycle("relock", 8'h57, 1'b1);
        cycle("relock", 8'h58, 1'b1);

        // Asynchronous reset during slot 2 of a frame.
        cycle("pre_rst", 8'hB0, 1'b1);
        cycle("pre_rst", 8'hB1, 1'b1);
        bus.data_in  = 8'hB2;
        bus.valid_in = 1'b1;
        #2;
        reset_L = 1'b0;
        model_reset();
        #1;
        compare_all("async_rst");
        @(negedge clk_4f);
        reset_L = 1'b1;
        compare_all("rst_release");
        cycle("post_rst", 8'hB3, 1'b0);
        for (int i = 0; i < 4; i++) cycle("post_rst", 8'(8'hC0 + i), 1'b1);

        // Randomized stream with segments of high, medium and low valid density.
        for (int seg = 0; seg < 40; seg++) begin
            case ($urandom_range(0, 2))
                0:       p = 95;
                1:       p = 70;
                default: p = 15;
            endcase
            for (int i = 0; i < 50; i++) begin
                cycle("random", 8'($urandom), $urandom_range(0, 99) < p);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/phy_rx_demux.md
Name: phy_rx_demux

Overview:
Receive-side counterpart of the phy_tx 4-to-1 lane mux tree. It takes the single byte stream arriving at clk_4f and distributes it round-robin onto four parallel 8-bit lanes. All four lanes update together once per 4-cycle frame. It sits in phy_rx behind the deserializer and feeds the four-lane downstream logic. It uses one clock; the f-rate timing is given by an output strobe, not by derived clocks.

Parameters:
WIDTH, 8, lane/byte data width
IDLE_LIMIT, 8, consecutive invalid input cycles in LOCKED that force return to SEEK (range 1..255)

Ports:
clk_4f  input  1  single clock; byte-rate clock
reset_L  input  1  asynchronous, active-low reset
data_in  input  WIDTH  incoming byte stream
valid_in  input  1  data_in qualifier
data_0  output  WIDTH  lane 0 byte (frame slot 0)
data_1  output  WIDTH  lane 1 byte (frame slot 1)
data_2  output  WIDTH  lane 2 byte (frame slot 2)
data_3  output  WIDTH  lane 3 byte (frame slot 3)
valid_0..valid_3  output  1 each  per-lane valid for the current frame
frame_strobe  output  1  one-cycle pulse when lane outputs update
locked  output  1  high while in LOCKED state

Behaviour:
- Interface: one clock, clk_4f. Reset is asynchronous and active-low on reset_L. While reset_L=0, all outputs are 0, FSM=SEEK, slot counter=0, idle counter=0 and capture registers are 0. Reset may assert mid-frame; the partial frame is discarded.
- State SEEK: slot counter is held at 0. The first cycle with valid_in=1 is taken as slot 0. That byte is captured into cap[0] with cv[0]=1. The slot counter goes to 1 and the FSM moves to LOCKED. Bytes with valid_in=0 in SEEK are ignored.
- State LOCKED: the 2-bit slot counter increments every cycle and wraps 3->0.
  - Each cycle, cap[slot]<=data_in and cv[slot]<=valid_in.
  - A capture register with valid_in=0 still records data_in, but its cv bit is 0.
- Frame output: in the cycle where slot==3 (LOCKED), at the next edge:
  - data_k<=cap[k] for k=0..2, and data_3<=data_in;
  - valid_k<=cv[k] for k=0..2, and valid_3<=valid_in;
  - frame_strobe<=1 for exactly one cycle.
  - Latency: slot-3 byte to output is 1 cycle; slot-0 byte to output is 4 cycles.
  - Outputs hold between strobes.
- Idle counter: in LOCKED it increments on valid_in=0 and clears on valid_in=1, saturating at IDLE_LIMIT.
- Loss of lock: when the idle count reaches IDLE_LIMIT, the FSM returns to SEEK at that edge.
  - If this coincides with slot==3, the frame output still occurs first in that same edge.
  - Otherwise the partial frame is dropped: no strobe, and captures are cleared.
  - All valid_k are driven 0 on the SEEK entry edge; data_k hold their last values.
- locked=1 exactly while FSM=LOCKED. It is registered and changes on the transition edge.
- No back-pressure; the block always accepts input.

Decomposition:
- Shared package phy_pkg: WIDTH default, NUM_LANES=4, SLOT_W=2, FSM state encoding (SEEK=1'b0, LOCKED=1'b1).
- Sub-module phy_rx_lock_fsm: SEEK/LOCKED FSM, slot counter, idle counter. It outputs slot, locked and a drop pulse.
- The datapath (capture and output registers) stays in phy_rx_demux.

Test Plan:
- Reset then stream 0xA0,0xA1,0xA2,0xA3 all valid -> locked=1 the cycle after 0xA0; frame_strobe one cycle after 0xA3; data_0..3=A0,A1,A2,A3; valid_0..3=1,1,1,1.
- Continuous stream 0x00..0x0F -> four strobes spaced exactly 4 cycles apart; lanes carry {00,01,02,03}, {04..07}, {08..0B}, {0C..0F}.
- Locked, with valid_in=0 on slot 2 only -> valid_2=0, other valids 1; data_2 equals the byte presented.
- Locked, then 8 consecutive invalid cycles -> locked drops on the 8th edge; no strobe for the partial frame; next valid byte 0x55 becomes lane 0 of a new frame.
- reset_L pulsed low during slot 2 -> all outputs 0 immediately (asynchronous); after release, the FSM is in SEEK; no stale bytes appear in the next frame.
- Idle invalid cycles before the first valid in SEEK -> no strobe and locked=0 until the first valid_in=1.
